// File: rtl/q2_sequencer_if.sv
// Q2 sequencer bus: front-panel controls and opcode bits in, state bits, write strobe and
// status out.
//   master : front panel / opcode register / control decoder side
//   slave  : the sequencer itself
// Optional: Q2_SEQ_INSTR_COUNT_EN adds the 16-bit instr_count output.
interface q2_sequencer_if;
    logic run;
    logic step;
    logic op2;
    logic op3;
    logic op4;
    logic op5;
    logic s0;
    logic s1;
    logic s2;
    logic s3;
    logic ws;
    logic halted;
    logic instr_done;
`ifdef Q2_SEQ_INSTR_COUNT_EN
    logic [15:0] instr_count;

    modport master (
        output run, step, op2, op3, op4, op5,
        input  s0, s1, s2, s3, ws, halted, instr_done, instr_count
    );

    modport slave (
        input  run, step, op2, op3, op4, op5,
        output s0, s1, s2, s3, ws, halted, instr_done, instr_count
    );
`else
    modport master (
        output run, step, op2, op3, op4, op5,
        input  s0, s1, s2, s3, ws, halted, instr_done
    );

    modport slave (
        input  run, step, op2, op3, op4, op5,
        output s0, s1, s2, s3, ws, halted, instr_done
    );
`endif
endinterface

// File: rtl/q2_sequencer.sv
// Timing and state sequencer for the Q2 CPU. Steps each instruction through FETCH, DEREF,
// LOAD, EXEC and the bit-serial ALU states, emitting state bits s0..s3 and a one-clock write
// strobe per active state. Front-panel run/step park the machine at FETCH phase 0.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : q2_sequencer_if.slave
//           in : run, step (asynchronous, synchronised here), op2..op5 (opcode register)
//           out: s0..s3, ws (registered), halted, instr_done (one-clk pulse on FETCH entry)
// Optional: define Q2_SEQ_INSTR_COUNT_EN to add the wrapping 16-bit instr_count output.
module q2_sequencer #(
    parameter int unsigned ALU_STEPS     = 8,  // 1..12
    parameter int unsigned SETTLE_CYCLES = 1   // 1..7
) (
    input  logic           clk,
    input  logic           rst_n,
    q2_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        StFetch = 3'd0,
        StDeref = 3'd1,
        StLoad  = 3'd2,
        StExec  = 3'd3,
        StAlu   = 3'd4
    } state_e;

    localparam logic [2:0] SettleMax = 3'(SETTLE_CYCLES);
    localparam logic [3:0] AluLast   = 4'(ALU_STEPS - 1);

    state_e     state_q, state_d;
    logic [3:0] alu_q, alu_d;
    logic [2:0] phase_q, phase_d;
    logic [3:0] s_q, s_d;
    logic       ws_q, ws_d;
    logic       done_q, done_d;
    logic       step_pend_q, step_pend_d;
    logic       run_meta_q, run_sync_q;
    logic       step_meta_q, step_sync_q, step_prev_q;

    logic go, parked, halted, step_edge, active, advance;

    assign go        = run_sync_q | step_pend_q;
    assign parked    = (state_q == StFetch) && (phase_q == 3'd0);
    assign halted    = parked & ~go;
    assign step_edge = step_sync_q & ~step_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_meta_q  <= 1'b0;
            run_sync_q  <= 1'b0;
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            run_meta_q  <= bus.run;
            run_sync_q  <= run_meta_q;
            step_meta_q <= bus.step;
            step_sync_q <= step_meta_q;
            step_prev_q <= step_sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            alu_q       <= 4'd0;
            phase_q     <= 3'd0;
            s_q         <= 4'd0;
            ws_q        <= 1'b0;
            done_q      <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_q       <= alu_d;
            phase_q     <= phase_d;
            s_q         <= s_d;
            ws_q        <= ws_d;
            done_q      <= done_d;
            step_pend_q <= step_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        alu_d       = alu_q;
        phase_d     = phase_q;
        done_d      = 1'b0;
        advance     = 1'b0;
        step_pend_d = step_pend_q;

        case (state_q)
            StDeref: active = bus.op2;
            StLoad:  active = ~bus.op5;
            default: active = 1'b1;
        endcase

        // A pending step is consumed by any departure from FETCH phase 0, so a step
        // captured just before run came on cannot leak into a later halt.
        if (parked && go) begin
            step_pend_d = 1'b0;
        end else if (step_edge && halted) begin
            step_pend_d = 1'b1;
        end

        // Skip decision is taken only at phase 0 so a late op change cannot cut an active
        // state short.
        if (halted) begin
            phase_d = 3'd0;
        end else if (((phase_q == 3'd0) && !active) || (phase_q == SettleMax)) begin
            advance = 1'b1;
        end else begin
            phase_d = phase_q + 3'd1;
        end

        if (advance) begin
            phase_d = 3'd0;
            case (state_q)
                StFetch: state_d = StDeref;
                StDeref: state_d = StLoad;
                StLoad:  state_d = StExec;
                StExec: begin
                    if ((~bus.op3 & ~bus.op4) | ~bus.op5) begin
                        state_d = StAlu;
                        alu_d   = 4'd0;
                    end else begin
                        state_d = StFetch;
                        done_d  = 1'b1;
                    end
                end
                StAlu: begin
                    if (alu_q == AluLast) begin
                        state_d = StFetch;
                        alu_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        alu_d = alu_q + 4'd1;
                    end
                end
                default: state_d = StFetch;
            endcase
        end

        // ws and s are precomputed from next state so the outputs come straight from flops.
        ws_d = (phase_d == SettleMax);
        if (state_d == StAlu) begin
            s_d = 4'd4 + alu_d;
        end else begin
            s_d = {1'b0, state_d};
        end
    end

`ifdef Q2_SEQ_INSTR_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else if (done_d) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bus.instr_count = count_q;
`endif

    assign bus.s0         = s_q[0];
    assign bus.s1         = s_q[1];
    assign bus.s2         = s_q[2];
    assign bus.s3         = s_q[3];
    assign bus.ws         = ws_q;
    assign bus.halted     = halted;
    assign bus.instr_done = done_q;

endmodule

// File: tb/tb_q2_sequencer.sv
// Randomised scoreboard bench for q2_sequencer: the driver pushes each instruction's expected
// write-strobe states and length, a negedge monitor pops and compares them.
module tb_q2_sequencer;

    localparam int AluSteps = 8;
    localparam int Settle   = 1;

    logic clk = 1'b0;
    logic rst_n;

    q2_sequencer_if bus ();

    q2_sequencer #(
        .ALU_STEPS     (AluSteps),
        .SETTLE_CYCLES (Settle)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ws_exp[$];
    int len_exp[$];
    int cyc      = 0;
    int ndone    = 0;
    bit mon_en   = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int cur_state();
        return int'({bus.s3, bus.s2, bus.s1, bus.s0});
    endfunction

    // Reference: an instruction is the list of states that strobe ws; each active state
    // lasts Settle+1 clocks, each skipped one lasts a single clock.
    task automatic push_model(input bit o2, input bit o3, input bit o4, input bit o5);
        int len;
        len = Settle + 1;
        ws_exp.push_back(0);
        if (o2) begin ws_exp.push_back(1); len += Settle + 1; end
        else len += 1;
        if (!o5) begin ws_exp.push_back(2); len += Settle + 1; end
        else len += 1;
        ws_exp.push_back(3);
        len += Settle + 1;
        if ((!o3 && !o4) || !o5) begin
            for (int k = 0; k < AluSteps; k++) begin
                ws_exp.push_back(4 + k);
                len += Settle + 1;
            end
        end
        len_exp.push_back(len);
    endtask

    task automatic set_ops(input bit o2, input bit o3, input bit o4, input bit o5);
        bus.op2 = o2;
        bus.op3 = o3;
        bus.op4 = o4;
        bus.op5 = o5;
        push_model(o2, o3, o4, o5);
    endtask

    task automatic set_rand_ops();
        logic [3:0] r;
        r = 4'($urandom);
        set_ops(r[0], r[1], r[2], r[3]);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.instr_done && n < budget);
        if (!bus.instr_done) check("done_timeout", 0, 1);
    endtask

    task automatic wait_state(input int code, input bit need_ws, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cur_state() == code && (bus.ws || !need_ws)) && n < budget);
        check("state_reached", cur_state(), code);
    endtask

    task automatic hold_check(input string name, input int cycles);
        int bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (!bus.halted || bus.ws || cur_state() != 0) bad++;
        end
        check(name, bad, 0);
    endtask

    // Monitor: every ws pulse and every instr_done is matched against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ws) begin
                if (ws_exp.size() == 0) check("ws_unexpected", cur_state(), -1);
                else check("ws_state", cur_state(), ws_exp.pop_front());
            end
            if (bus.instr_done) begin
                ndone++;
                if (len_exp.size() == 0) check("done_unexpected", cyc, -1);
                else check("instr_len", cyc, len_exp.pop_front());
                cyc = bus.halted ? 0 : 1;
            end else if (!bus.halted) begin
                cyc++;
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        bus.run  = 1'b0;
        bus.step = 1'b0;
        bus.op2  = 1'b0;
        bus.op3  = 1'b0;
        bus.op4  = 1'b0;
        bus.op5  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", cur_state(), 0);
        check("rst_ws", int'(bus.ws), 0);
        check("rst_halted", int'(bus.halted), 1);
        check("rst_done", int'(bus.instr_done), 0);
        rst_n = 1'b1;
        hold_check("idle_hold", 8);

        // Single step of a jump-type instruction.
        set_ops(1'b0, 1'b1, 1'b1, 1'b1);
        bus.step = 1'b1;
        wait_done(100);
        check("step_halted_after", int'(bus.halted), 1);
        bus.step = 1'b0;
        hold_check("step_hold", 10);
        check("step_queue_empty", ws_exp.size() + len_exp.size(), 0);

        // Running: directed patterns, then random ones with step chatter that must be ignored.
        bus.run = 1'b1;
        set_ops(1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(200);
        check("run_halted", int'(bus.halted), 0);
        set_ops(1'b0, 1'b1, 1'b0, 1'b1);
        wait_done(200);
        set_ops(1'b0, 1'b0, 1'b1, 1'b1);
        wait_done(200);
        for (int i = 0; i < 30; i++) begin
            bus.step = 1'($urandom);
            set_rand_ops();
            wait_done(200);
            if (bus.instr_done) check("run_halted_loop", int'(bus.halted), 0);
        end
        bus.step = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_rand_ops();
            wait_done(200);
        end

        // Drop run during ALU_3: instruction finishes, then the machine parks.
        set_ops(1'b1, 1'b0, 1'b0, 1'b0);
        wait_state(7, 1'b0, 100);
        bus.run = 1'b0;
        wait_done(100);
        check("drop_halted", int'(bus.halted), 1);
        hold_check("drop_hold", 25);
        check("drop_queue_empty", ws_exp.size() + len_exp.size(), 0);

        // Step and run together run normally; no stale step survives the halt.
        set_rand_ops();
        bus.step = 1'b1;
        bus.run  = 1'b1;
        wait_done(200);
        for (int i = 0; i < 2; i++) begin
            set_rand_ops();
            wait_done(200);
        end
        set_rand_ops();
        bus.run  = 1'b0;
        bus.step = 1'b0;
        wait_done(200);
        check("both_halted", int'(bus.halted), 1);
        hold_check("both_hold", 12);
        check("both_queue_empty", ws_exp.size() + len_exp.size(), 0);
`ifdef Q2_SEQ_INSTR_COUNT_EN
        check("instr_count", int'(bus.instr_count), ndone % 65536);
`endif

        // Asynchronous reset in the EXEC ws cycle.
        set_ops(1'b1, 1'b0, 1'b0, 1'b0);
        bus.run = 1'b1;
        wait_state(3, 1'b1, 100);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", cur_state(), 0);
        check("arst_ws", int'(bus.ws), 0);
        check("arst_halted", int'(bus.halted), 1);
        bus.run = 1'b0;
        ws_exp.delete();
        len_exp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
